// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single register-file write port between the
// in-order pipeline writeback and a buffered multiply/divide result stream.
// Pipeline writes always win. Mul/div results queue in a DEPTH-entry FIFO and
// drain on cycles with no pipeline write. A starvation counter requests a WB
// bubble from the hazard unit once the FIFO has lost MAX_WAIT cycles in a row.
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RegWriteW,
  input  logic [4:0]               WriteRegW,
  input  logic [31:0]              ResultW,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [4:0]               md_reg,
  input  logic [31:0]              md_data,
  input  logic                     md_flush,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     md_pending,
  output logic                     stall_req,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } md_entry_t;

  md_entry_t         r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic [WW-1:0]     r_wait;
  logic              r_rf_we;
  logic [4:0]        r_rf_waddr;
  logic [31:0]       r_rf_wdata;

  logic              w_pipe_req;
  logic              w_enq;
  logic              w_deq;
  logic              w_fifo_nonempty;
  md_entry_t         w_head;

  // Request/grant decode; everything here depends only on inputs and
  // registered state, and md_ready depends on the registered count alone.
  always_comb begin
    w_fifo_nonempty = (r_count != '0);
    w_pipe_req      = RegWriteW && (WriteRegW != 5'd0);
    md_ready        = (r_count < CW'(DEPTH));
    w_enq           = md_valid && md_ready && !md_flush;
    w_deq           = !w_pipe_req && w_fifo_nonempty && !md_flush;
    w_head          = r_mem[r_head];
  end

  // FIFO storage: written on enqueue only.
  // NOTE: the entry array has no reset; validity is tracked by the pointers
  // and count, so resetting the storage would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_enq) r_mem[r_tail] <= '{rd: md_reg, data: md_data};
  end

  // FIFO pointers and occupancy; flush empties the queue in one edge.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (md_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + AW'(1);
      if (w_deq) r_head <= r_head + AW'(1);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  // Starvation counter: counts consecutive cycles the FIFO held data but lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (md_flush || !w_fifo_nonempty || !w_pipe_req) begin
      r_wait <= '0;
    end else if (r_wait != WW'(MAX_WAIT)) begin
      r_wait <= r_wait + WW'(1);
    end
  end

  // Registered write port: pipeline first, then FIFO head, else idle (hold).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= 5'd0;
      r_rf_wdata <= 32'd0;
    end else if (w_pipe_req) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= WriteRegW;
      r_rf_wdata <= ResultW;
    end else if (w_deq) begin
      r_rf_we    <= (w_head.rd != 5'd0);
      r_rf_waddr <= w_head.rd;
      r_rf_wdata <= w_head.data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign fifo_count = r_count;
  assign md_pending = w_fifo_nonempty;
  assign stall_req  = (r_wait == WW'(MAX_WAIT));

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run, all
// checked against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int CW       = $clog2(DEPTH) + 1;

  logic           clk;
  logic           rst_n;
  logic           RegWriteW;
  logic [4:0]     WriteRegW;
  logic [31:0]    ResultW;
  logic           md_valid;
  logic           md_ready;
  logic [4:0]     md_reg;
  logic [31:0]    md_data;
  logic           md_flush;
  logic           rf_we;
  logic [4:0]     rf_waddr;
  logic [31:0]    rf_wdata;
  logic           md_pending;
  logic           stall_req;
  logic [CW-1:0]  fifo_count;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWriteW  (RegWriteW),
    .WriteRegW  (WriteRegW),
    .ResultW    (ResultW),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_reg     (md_reg),
    .md_data    (md_data),
    .md_flush   (md_flush),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .md_pending (md_pending),
    .stall_req  (stall_req),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: arrival-ordered queue, loss counter, expected port regs.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  int          m_wait;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  int vectors;
  int miscompares;

  task automatic model_reset();
    q.delete();
    m_wait = 0;
    m_we   = 1'b0;
    m_addr = 5'd0;
    m_data = 32'd0;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int   n;
    bit   preq;
    ent_t e;
    n    = q.size();
    preq = RegWriteW && (WriteRegW != 5'd0);
    if (preq) begin
      m_we = 1'b1; m_addr = WriteRegW; m_data = ResultW;
    end else if (n > 0 && !md_flush) begin
      e = q.pop_front();
      m_we = (e.rd != 5'd0); m_addr = e.rd; m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (md_flush || n == 0 || !preq) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    if (md_flush) q.delete();
    else if (md_valid && n < DEPTH) q.push_back('{rd: md_reg, data: md_data});
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    RegWriteW = 1'b0; WriteRegW = 5'd0; ResultW = 32'd0;
    md_valid  = 1'b0; md_reg    = 5'd0; md_data = 32'd0;
    md_flush  = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata} !== 38'd0) begin
      miscompares++;
      $display("FAIL reset_rf: got we=%0b addr=%0d data=%0h expected all 0", rf_we, rf_waddr, rf_wdata);
    end
    vectors++;
    if ({fifo_count, md_pending, stall_req, md_ready} !== {CW'(0), 3'b001}) begin
      miscompares++;
      $display("FAIL reset_status: got count=%0d pend=%0b stall=%0b ready=%0b expected 0 0 0 1",
               fifo_count, md_pending, stall_req, md_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_pipe_write();
    RegWriteW = 1'b1; WriteRegW = 5'd5; ResultW = 32'hDEADBEEF;
    tick();
    set_idle();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL pipe_write: got we=%0b addr=%0d data=%0h expected 1 5 deadbeef", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    vectors++;
    if ({rf_we, rf_waddr} !== {1'b0, 5'd5}) begin
      miscompares++;
      $display("FAIL pipe_idle_hold: got we=%0b addr=%0d expected 0 5", rf_we, rf_waddr);
    end
  endtask

  task automatic test_md_single();
    md_valid = 1'b1; md_reg = 5'd7; md_data = 32'h11;
    tick();
    set_idle();
    vectors++;
    if ({fifo_count, md_pending, rf_we} !== {CW'(1), 2'b10}) begin
      miscompares++;
      $display("FAIL md_enqueue: got count=%0d pend=%0b we=%0b expected 1 1 0", fifo_count, md_pending, rf_we);
    end
    tick();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, fifo_count} !== {1'b1, 5'd7, 32'h11, CW'(0)}) begin
      miscompares++;
      $display("FAIL md_drain: got we=%0b addr=%0d data=%0h count=%0d expected 1 7 11 0",
               rf_we, rf_waddr, rf_wdata, fifo_count);
    end
  endtask

  task automatic test_full_starve();
    for (int i = 0; i < 9; i++) begin
      RegWriteW = 1'b1; WriteRegW = 5'(1 + i); ResultW = 32'(i);
      md_valid  = 1'b1;
      if (i < DEPTH + 1) begin md_reg = 5'(10 + i); md_data = 32'h100 + 32'(i); end
      tick();
      vectors++;
      if ({fifo_count, md_ready, stall_req} !== {CW'(q.size()), q.size() < DEPTH, m_wait == MAX_WAIT}) begin
        miscompares++;
        $display("FAIL starve_step%0d: got count=%0d ready=%0b stall=%0b expected %0d %0b %0b", i,
                 fifo_count, md_ready, stall_req, q.size(), q.size() < DEPTH, m_wait == MAX_WAIT);
      end
    end
    vectors++;
    if ({fifo_count, md_ready, stall_req} !== {CW'(DEPTH), 2'b01}) begin
      miscompares++;
      $display("FAIL starve_full: got count=%0d ready=%0b stall=%0b expected 4 0 1", fifo_count, md_ready, stall_req);
    end
    // Drain cycle with the fifth offer still held: full, so no enqueue.
    RegWriteW = 1'b0;
    tick();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, stall_req, fifo_count} !== {1'b1, 5'd10, 32'h100, 1'b0, CW'(3)}) begin
      miscompares++;
      $display("FAIL starve_drain: got we=%0b addr=%0d data=%0h stall=%0b count=%0d expected 1 10 100 0 3",
               rf_we, rf_waddr, rf_wdata, stall_req, fifo_count);
    end
    set_idle();
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      vectors++;
      if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(10 + i), 32'h100 + 32'(i)}) begin
        miscompares++;
        $display("FAIL order_%0d: got we=%0b addr=%0d data=%0h expected 1 %0d %0h", i,
                 rf_we, rf_waddr, rf_wdata, 10 + i, 32'h100 + 32'(i));
      end
    end
    vectors++;
    if (fifo_count !== CW'(0)) begin
      miscompares++;
      $display("FAIL order_empty: got count=%0d expected 0", fifo_count);
    end
  endtask

  task automatic test_reg_zero();
    md_valid = 1'b1; md_reg = 5'd0; md_data = 32'hAAAA;
    tick();
    md_reg = 5'd3; md_data = 32'h3333;
    tick();
    md_valid = 1'b0;
    vectors++;
    if ({rf_we, fifo_count} !== {1'b0, CW'(1)}) begin
      miscompares++;
      $display("FAIL reg0_consume: got we=%0b count=%0d expected 0 1", rf_we, fifo_count);
    end
    tick();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, fifo_count} !== {1'b1, 5'd3, 32'h3333, CW'(0)}) begin
      miscompares++;
      $display("FAIL reg3_write: got we=%0b addr=%0d data=%0h count=%0d expected 1 3 3333 0",
               rf_we, rf_waddr, rf_wdata, fifo_count);
    end
    RegWriteW = 1'b1; WriteRegW = 5'd0; ResultW = 32'h5555;
    tick();
    set_idle();
    vectors++;
    if ({rf_we, rf_waddr} !== {1'b0, 5'd3}) begin
      miscompares++;
      $display("FAIL pipe_reg0: got we=%0b addr=%0d expected 0 3", rf_we, rf_waddr);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      RegWriteW = 1'b1; WriteRegW = 5'd1; ResultW = 32'(i);
      md_valid  = 1'b1; md_reg = 5'(20 + i); md_data = 32'(i);
      tick();
    end
    vectors++;
    if (fifo_count !== CW'(3)) begin
      miscompares++;
      $display("FAIL flush_fill: got count=%0d expected 3", fifo_count);
    end
    md_flush = 1'b1; md_reg = 5'd30;
    WriteRegW = 5'd9; ResultW = 32'h99;
    tick();
    set_idle();
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, fifo_count, md_pending} !== {1'b1, 5'd9, 32'h99, CW'(0), 1'b0}) begin
      miscompares++;
      $display("FAIL flush: got we=%0b addr=%0d data=%0h count=%0d pend=%0b expected 1 9 99 0 0",
               rf_we, rf_waddr, rf_wdata, fifo_count, md_pending);
    end
    tick();
    vectors++;
    if ({rf_we, fifo_count} !== {1'b0, CW'(0)}) begin
      miscompares++;
      $display("FAIL flush_after: got we=%0b count=%0d expected 0 0", rf_we, fifo_count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      RegWriteW = 1'b1; WriteRegW = 5'd2; ResultW = 32'(i);
      md_valid  = 1'b1; md_reg = 5'(4 + i); md_data = 32'hC0 + 32'(i);
      tick();
    end
    set_idle();
    tick();
    vectors++;
    if ({rf_we, rf_waddr, fifo_count} !== {1'b1, 5'd4, CW'(2)}) begin
      miscompares++;
      $display("FAIL mid_drain: got we=%0b addr=%0d count=%0d expected 1 4 2", rf_we, rf_waddr, fifo_count);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({rf_we, rf_waddr, rf_wdata, fifo_count, md_pending, stall_req, md_ready} !==
        {38'd0, CW'(0), 3'b001}) begin
      miscompares++;
      $display("FAIL async_reset: got we=%0b addr=%0d data=%0h count=%0d pend=%0b stall=%0b ready=%0b expected 0s ready=1",
               rf_we, rf_waddr, rf_wdata, fifo_count, md_pending, stall_req, md_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({rf_we, fifo_count} !== {1'b0, CW'(0)}) begin
        miscompares++;
        $display("FAIL post_reset_%0d: got we=%0b count=%0d expected 0 0", i, rf_we, fifo_count);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      RegWriteW = ($urandom_range(0, 99) < 55);
      WriteRegW = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      ResultW   = $urandom;
      md_valid  = ($urandom_range(0, 1) == 1);
      md_reg    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      md_data   = $urandom;
      md_flush  = ($urandom_range(0, 99) < 3);
      tick();
      vectors++;
      if (rf_we !== m_we) begin
        miscompares++;
        $display("FAIL rand_we@%0d: got %0b expected %0b", c, rf_we, m_we);
      end
      vectors++;
      if ({rf_waddr, rf_wdata} !== {m_addr, m_data}) begin
        miscompares++;
        $display("FAIL rand_wr@%0d: got addr=%0d data=%0h expected %0d %0h", c, rf_waddr, rf_wdata, m_addr, m_data);
      end
      vectors++;
      if ({fifo_count, md_pending, md_ready} !== {CW'(q.size()), q.size() != 0, q.size() < DEPTH}) begin
        miscompares++;
        $display("FAIL rand_fifo@%0d: got count=%0d pend=%0b ready=%0b expected %0d", c,
                 fifo_count, md_pending, md_ready, q.size());
      end
      vectors++;
      if (stall_req !== (m_wait == MAX_WAIT)) begin
        miscompares++;
        $display("FAIL rand_stall@%0d: got %0b expected %0b", c, stall_req, m_wait == MAX_WAIT);
      end
    end
    set_idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_pipe_write();
    test_md_single();
    test_full_starve();
    test_reg_zero();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (MEM/WB outputs) and a long-latency multiply/divide unit that returns results out of band. Pipeline writes always win; multiply/divide results wait in a DEPTH-entry FIFO and drain on cycles with no pipeline write. A starvation counter raises a stall request to the hazard unit so buffered results cannot wait forever. Sits between the WB stage / mul-div unit and the register file write port.

## Interface

- DEPTH, 4, FIFO entries for mul/div results; power of two, ≥2
- MAX_WAIT, 8, consecutive lost arbitration cycles before stall_req asserts; ≥1

- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- RegWriteW  in  1  pipeline WB write enable
- WriteRegW  in  5  pipeline WB destination register
- ResultW  in  32  pipeline WB write data
- md_valid  in  1  mul/div result offered
- md_ready  out  1  arbiter accepts mul/div result this cycle
- md_reg  in  5  mul/div destination register
- md_data  in  32  mul/div result data
- md_flush  in  1  discard all buffered mul/div results (exception/flush)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  32  register-file write data (registered)
- md_pending  out  1  FIFO non-empty (for hazard unit scoreboard)
- stall_req  out  1  request the hazard unit to insert a WB bubble
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation

- Enqueue: md_valid && md_ready writes {md_reg, md_data} at tail. md_ready = (fifo_count < DEPTH), derived only from registered count; no enqueue when full, even if a dequeue occurs that cycle.
- Pipeline request = RegWriteW && WriteRegW != 0. RegWriteW with WriteRegW == 0 is no request.
- Grant each cycle: pipeline request → pipeline; else fifo_count > 0 → FIFO head dequeued; else idle.
- Pipeline grant: next edge rf_we=1, rf_waddr=WriteRegW, rf_wdata=ResultW.
- FIFO grant: head popped; next edge rf_we = (head reg != 0), rf_waddr/rf_wdata = head fields. Head with reg 0 is consumed with no write.
- Idle: rf_we=0; rf_waddr/rf_wdata hold previous values.
- FIFO order strictly arrival order; no address comparison between pipeline and FIFO writes (ordering is the hazard unit's job, using md_pending).
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance; pointers wrap modulo DEPTH.
- Starvation: wait_cnt increments (saturating at MAX_WAIT) each cycle fifo_count > 0 and the pipeline wins; cleared on any FIFO dequeue or when fifo_count == 0. stall_req = (wait_cnt == MAX_WAIT).
- md_flush: next edge count, head, tail, wait_cnt = 0; any enqueue and any FIFO dequeue that cycle are suppressed; a pipeline grant that cycle still proceeds.
- Reset (async, rst_n low): rf_we=0, rf_waddr=0, rf_wdata=0, fifo_count=0, md_pending=0, stall_req=0, wait_cnt=0, pointers 0; md_ready=1 (count 0). Reset mid-drain discards all buffered entries.

## Timing

- Pipeline write: WB inputs in cycle N → rf_we high after edge N+1 (one-cycle latency).
- Mul/div result: handshake in cycle N → earliest rf_we at edge N+2 (entry visible to arbitration in N+1).
- md_pending and fifo_count update at the edge after enqueue/dequeue.
- stall_req rises the cycle after the MAX_WAIT-th consecutive loss; falls the cycle after the FIFO dequeue.
- No combinational path from md_valid to md_ready, or from any input to rf_* outputs.

## Test plan

- Reset then RegWriteW=1, WriteRegW=5, ResultW=0xDEADBEEF one cycle → next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- Pipeline idle, enqueue {reg 7, 0x11} in cycle N → fifo_count=1 at N+1, rf_we=1 addr 7 data 0x11 at N+2, fifo_count=0.
- Enqueue DEPTH=4 entries while pipeline writes every cycle → md_ready=0 at count 4, fifth offer held; after MAX_WAIT=8 losses stall_req=1; one RegWriteW=0 cycle drains head, stall_req=0 next cycle.
- Enqueue entries with reg 0 and reg 3 → reg 0 entry consumed with rf_we=0, reg 3 written next idle cycle; writes to reg 0 from pipeline never assert rf_we.
- FIFO holding 3 entries, md_flush with simultaneous md_valid and pipeline write to reg 9 → rf write to reg 9 occurs, fifo_count=0, md_pending=0, no FIFO write follows.
- Assert rst_n=0 asynchronously mid-drain (count 2) → all outputs immediately 0, md_ready=1; after release no buffered entry is written.
